// File: rtl/dispatch_scheduler.sv
// In-order decode->dispatch buffer: releases at most one instruction per cycle when ROB and RS/LSQ credits allow.
// Latency: enqueue at edge E, dispatch strobe at E+1 at the earliest; dec_ready_out drops when the FIFO is full.
module dispatch_scheduler #(
  parameter int QDEPTH   = 4,
  parameter int ROB_SIZE = 16,
  parameter int RS_SIZE  = 16,
  parameter int LSQ_SIZE = 16,
  parameter int LS_LO    = 11,
  parameter int LS_HI    = 18
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           rdy_in,
  input  logic                           flush_in,
  input  logic                           dec_valid_in,
  output logic                           dec_ready_out,
  input  logic [5:0]                     dec_inst_type_in,
  input  logic [4:0]                     dec_rs1_in,
  input  logic [4:0]                     dec_rs2_in,
  input  logic [4:0]                     dec_rd_in,
  input  logic [31:0]                    dec_imm_in,
  input  logic [31:0]                    dec_pc_in,
  output logic                           disp_en_out,
  output logic [5:0]                     disp_inst_type_out,
  output logic [4:0]                     disp_rs1_out,
  output logic [4:0]                     disp_rs2_out,
  output logic [4:0]                     disp_rd_out,
  output logic [31:0]                    disp_imm_out,
  output logic [31:0]                    disp_pc_out,
  output logic                           disp_is_ls_out,
  input  logic                           rob_free_in,
  input  logic                           rs_free_in,
  input  logic                           lsq_free_in,
  output logic [$clog2(ROB_SIZE+1)-1:0]  rob_credit_out,
  output logic [$clog2(RS_SIZE+1)-1:0]   rs_credit_out,
  output logic [$clog2(LSQ_SIZE+1)-1:0]  lsq_credit_out
);

  localparam int PW   = $clog2(QDEPTH);
  localparam int CW   = $clog2(QDEPTH + 1);
  localparam int ROBW = $clog2(ROB_SIZE + 1);
  localparam int RSW  = $clog2(RS_SIZE + 1);
  localparam int LSQW = $clog2(LSQ_SIZE + 1);

  localparam logic [5:0]      LS_LO_T = 6'(LS_LO);
  localparam logic [5:0]      LS_HI_T = 6'(LS_HI);
  localparam logic [CW-1:0]   QDEPTH_C = CW'(QDEPTH);
  localparam logic [ROBW-1:0] ROB_MAX = ROBW'(ROB_SIZE);
  localparam logic [RSW-1:0]  RS_MAX  = RSW'(RS_SIZE);
  localparam logic [LSQW-1:0] LSQ_MAX = LSQW'(LSQ_SIZE);

  typedef struct packed {
    logic [5:0]  inst_type;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        is_ls;
  } entry_t;

  // Net credit update with saturation; underflow is prevented by the go condition.
  function automatic int credit_next(input int cur, input int max, input logic inc, input logic dec);
    int n;
    n = cur + int'(inc) - int'(dec);
    return (n > max) ? max : n;
  endfunction

  entry_t          mem_q [QDEPTH];
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [ROBW-1:0] rob_credit_q, rob_credit_d;
  logic [RSW-1:0]  rs_credit_q, rs_credit_d;
  logic [LSQW-1:0] lsq_credit_q, lsq_credit_d;
  entry_t          disp_q, disp_d;
  logic            disp_en_q, disp_en_d;

  entry_t enq_ent;
  entry_t head_ent;
  logic   enq;
  logic   go;
  logic   credit_ok;

  assign dec_ready_out = (count_q < QDEPTH_C);
  assign enq           = dec_valid_in && dec_ready_out && rdy_in && !flush_in;
  assign head_ent      = mem_q[head_q];

  always_comb begin
    enq_ent           = '0;
    enq_ent.inst_type = dec_inst_type_in;
    enq_ent.rs1       = dec_rs1_in;
    enq_ent.rs2       = dec_rs2_in;
    enq_ent.rd        = dec_rd_in;
    enq_ent.imm       = dec_imm_in;
    enq_ent.pc        = dec_pc_in;
    enq_ent.is_ls     = (dec_inst_type_in >= LS_LO_T) && (dec_inst_type_in <= LS_HI_T);
  end

  assign credit_ok = (rob_credit_q != '0) &&
                     (head_ent.is_ls ? (lsq_credit_q != '0) : (rs_credit_q != '0));
  assign go        = (count_q != '0) && rdy_in && !flush_in && credit_ok;

  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    rob_credit_d = rob_credit_q;
    rs_credit_d  = rs_credit_q;
    lsq_credit_d = lsq_credit_q;
    disp_d       = disp_q;
    disp_en_d    = 1'b0;
    if (rdy_in) begin
      if (flush_in) begin
        head_d       = '0;
        tail_d       = '0;
        count_d      = '0;
        rob_credit_d = ROB_MAX;
        rs_credit_d  = RS_MAX;
        lsq_credit_d = LSQ_MAX;
      end else begin
        if (go) begin
          head_d    = head_q + PW'(1);
          disp_d    = head_ent;
          disp_en_d = 1'b1;
        end
        if (enq) begin
          tail_d = tail_q + PW'(1);
        end
        count_d      = count_q + CW'(enq) - CW'(go);
        rob_credit_d = ROBW'(credit_next(int'(rob_credit_q), ROB_SIZE, rob_free_in, go));
        rs_credit_d  = RSW'(credit_next(int'(rs_credit_q), RS_SIZE, rs_free_in,
                                        go && !head_ent.is_ls));
        lsq_credit_d = LSQW'(credit_next(int'(lsq_credit_q), LSQ_SIZE, lsq_free_in,
                                         go && head_ent.is_ls));
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      rob_credit_q <= ROB_MAX;
      rs_credit_q  <= RS_MAX;
      lsq_credit_q <= LSQ_MAX;
      disp_q       <= '0;
      disp_en_q    <= 1'b0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      rob_credit_q <= rob_credit_d;
      rs_credit_q  <= rs_credit_d;
      lsq_credit_q <= lsq_credit_d;
      disp_q       <= disp_d;
      disp_en_q    <= disp_en_d;
    end
  end

  // Payload storage needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clk_in) begin
    if (enq) begin
      mem_q[tail_q] <= enq_ent;
    end
  end

  assign disp_en_out        = disp_en_q;
  assign disp_inst_type_out = disp_q.inst_type;
  assign disp_rs1_out       = disp_q.rs1;
  assign disp_rs2_out       = disp_q.rs2;
  assign disp_rd_out        = disp_q.rd;
  assign disp_imm_out       = disp_q.imm;
  assign disp_pc_out        = disp_q.pc;
  assign disp_is_ls_out     = disp_q.is_ls;
  assign rob_credit_out     = rob_credit_q;
  assign rs_credit_out      = rs_credit_q;
  assign lsq_credit_out     = lsq_credit_q;

endmodule

// File: tb/tb_dispatch_scheduler.sv
// Bench for dispatch_scheduler: queue-based reference model checked every cycle, plus directed scenarios.
module tb_dispatch_scheduler;

  localparam int QDEPTH = 4;
  localparam int SZ     = 16;

  logic        clk_in, rst_n, rdy_in, flush_in;
  logic        dec_valid_in, dec_ready_out;
  logic [5:0]  dec_inst_type_in;
  logic [4:0]  dec_rs1_in, dec_rs2_in, dec_rd_in;
  logic [31:0] dec_imm_in, dec_pc_in;
  logic        disp_en_out;
  logic [5:0]  disp_inst_type_out;
  logic [4:0]  disp_rs1_out, disp_rs2_out, disp_rd_out;
  logic [31:0] disp_imm_out, disp_pc_out;
  logic        disp_is_ls_out;
  logic        rob_free_in, rs_free_in, lsq_free_in;
  logic [4:0]  rob_credit_out, rs_credit_out, lsq_credit_out;

  dispatch_scheduler #(.QDEPTH(QDEPTH), .ROB_SIZE(SZ), .RS_SIZE(SZ), .LSQ_SIZE(SZ),
                       .LS_LO(11), .LS_HI(18)) dut (
    .clk_in(clk_in), .rst_in(rst_n), .rdy_in(rdy_in), .flush_in(flush_in),
    .dec_valid_in(dec_valid_in), .dec_ready_out(dec_ready_out),
    .dec_inst_type_in(dec_inst_type_in), .dec_rs1_in(dec_rs1_in), .dec_rs2_in(dec_rs2_in),
    .dec_rd_in(dec_rd_in), .dec_imm_in(dec_imm_in), .dec_pc_in(dec_pc_in),
    .disp_en_out(disp_en_out), .disp_inst_type_out(disp_inst_type_out),
    .disp_rs1_out(disp_rs1_out), .disp_rs2_out(disp_rs2_out), .disp_rd_out(disp_rd_out),
    .disp_imm_out(disp_imm_out), .disp_pc_out(disp_pc_out), .disp_is_ls_out(disp_is_ls_out),
    .rob_free_in(rob_free_in), .rs_free_in(rs_free_in), .lsq_free_in(lsq_free_in),
    .rob_credit_out(rob_credit_out), .rs_credit_out(rs_credit_out), .lsq_credit_out(lsq_credit_out)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  int tests = 0;
  int fails = 0;
  int strobes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of instructions plus three integer credit pools.
  typedef struct {
    logic [5:0]  t;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm, pc;
  } ent_t;

  ent_t mq[$];
  ent_t m_f;
  int   m_rob, m_rs, m_lsq;
  bit   m_en, m_is_ls, mgo, mls;

  function automatic bit is_ls_t(input logic [5:0] t);
    return (t >= 6'd11) && (t <= 6'd18);
  endfunction

  function automatic int cap(input int v);
    return (v > SZ) ? SZ : v;
  endfunction

  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_rob = SZ; m_rs = SZ; m_lsq = SZ;
      m_en = 0; m_is_ls = 0;
      m_f = '{t: 6'd0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0, imm: 32'd0, pc: 32'd0};
    end else if (!rdy_in) begin
      m_en = 0;
    end else if (flush_in) begin
      mq.delete();
      m_rob = SZ; m_rs = SZ; m_lsq = SZ;
      m_en = 0;
    end else begin
      bit room;
      room = (mq.size() < QDEPTH);
      mgo = 0;
      mls = 0;
      if (mq.size() > 0) begin
        mls = is_ls_t(mq[0].t);
        mgo = (m_rob > 0) && (mls ? (m_lsq > 0) : (m_rs > 0));
      end
      m_en = mgo;
      if (mgo) begin
        m_f = mq.pop_front();
        m_is_ls = mls;
      end
      if (dec_valid_in && room)
        mq.push_back('{t: dec_inst_type_in, rs1: dec_rs1_in, rs2: dec_rs2_in, rd: dec_rd_in,
                       imm: dec_imm_in, pc: dec_pc_in});
      m_rob = cap(m_rob + int'(rob_free_in) - int'(mgo));
      m_rs  = cap(m_rs + int'(rs_free_in) - int'(mgo && !mls));
      m_lsq = cap(m_lsq + int'(lsq_free_in) - int'(mgo && mls));
    end
  end

  always @(negedge clk_in) begin
    if (disp_en_out === 1'b1) strobes++;
    if (rst_n) begin
      chk("cyc_disp_en", disp_en_out, m_en);
      chk("cyc_ready", dec_ready_out, mq.size() < QDEPTH);
      chk("cyc_rob_credit", rob_credit_out, m_rob);
      chk("cyc_rs_credit", rs_credit_out, m_rs);
      chk("cyc_lsq_credit", lsq_credit_out, m_lsq);
      chk("cyc_type", disp_inst_type_out, m_f.t);
      chk("cyc_rs1", disp_rs1_out, m_f.rs1);
      chk("cyc_rs2", disp_rs2_out, m_f.rs2);
      chk("cyc_rd", disp_rd_out, m_f.rd);
      chk("cyc_imm", disp_imm_out, m_f.imm);
      chk("cyc_pc", disp_pc_out, m_f.pc);
      chk("cyc_is_ls", disp_is_ls_out, m_is_ls);
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_op(input logic [5:0] ty, input logic [4:0] rd, input logic [31:0] pc);
    dec_inst_type_in = ty;
    dec_rd_in        = rd;
    dec_rs1_in       = rd + 5'd1;
    dec_rs2_in       = rd ^ 5'h1f;
    dec_imm_in       = pc + 32'h10;
    dec_pc_in        = pc;
  endtask

  // Pushes n ops, waiting (bounded) for dec_ready_out before each one.
  task automatic push_ops(input int n, input logic [5:0] ty, input bit cyc8, input logic [31:0] pc0);
    for (int i = 0; i < n; i++) begin
      int w;
      w = 0;
      dec_valid_in = 1'b0;
      while (dec_ready_out !== 1'b1 && w < 100) begin
        tick();
        w++;
      end
      if (w >= 100) begin
        chk("push_ready_timeout", dec_ready_out, 1'b1);
        return;
      end
      set_op(cyc8 ? 6'(11 + i % 8) : ty, 5'(i), pc0 + 32'(4 * i));
      dec_valid_in = 1'b1;
      tick();
    end
    dec_valid_in = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    int s0;
    rst_n = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; dec_valid_in = 1'b0;
    rob_free_in = 1'b0; rs_free_in = 1'b0; lsq_free_in = 1'b0;
    set_op(6'd0, 5'd0, 32'd0);
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_disp_en", disp_en_out, 1'b0);
    chk("rst_disp_pc", disp_pc_out, 32'd0);
    chk("rst_disp_rd", disp_rd_out, 5'd0);
    chk("rst_rob", rob_credit_out, 5'd16);
    chk("rst_rs", rs_credit_out, 5'd16);
    chk("rst_lsq", lsq_credit_out, 5'd16);
    rst_n = 1'b1;
    tick();
    chk("rst_ready", dec_ready_out, 1'b1);

    // Single ADD: no same-cycle bypass, strobe one edge after enqueue.
    set_op(6'd1, 5'd5, 32'h100);
    dec_imm_in = 32'h10;
    dec_valid_in = 1'b1;
    tick();
    dec_valid_in = 1'b0;
    chk("t1_no_bypass", disp_en_out, 1'b0);
    tick();
    chk("t1_en", disp_en_out, 1'b1);
    chk("t1_rd", disp_rd_out, 5'd5);
    chk("t1_pc", disp_pc_out, 32'h100);
    chk("t1_imm", disp_imm_out, 32'h10);
    chk("t1_is_ls", disp_is_ls_out, 1'b0);
    chk("t1_rob", rob_credit_out, 5'd15);
    chk("t1_rs", rs_credit_out, 5'd15);
    chk("t1_lsq", lsq_credit_out, 5'd16);
    tick();
    chk("t1_one_shot", disp_en_out, 1'b0);
    flush_in = 1'b1; tick(); flush_in = 1'b0;

    // RS exhaustion: 16 strobes, 17th held, FIFO fills, one rs_free releases it.
    rob_free_in = 1'b1;
    s0 = strobes;
    push_ops(20, 6'd1, 1'b0, 32'h1000);
    repeat (5) tick();
    chk("t2_strobes", strobes - s0, 16);
    chk("t2_full", dec_ready_out, 1'b0);
    chk("t2_rs", rs_credit_out, 5'd0);
    chk("t2_rob_sat", rob_credit_out, 5'd16);
    rs_free_in = 1'b1; tick(); rs_free_in = 1'b0;
    chk("t2_wait", disp_en_out, 1'b0);
    tick();
    chk("t2_release", disp_en_out, 1'b1);
    chk("t2_release_pc", disp_pc_out, 32'h1040);
    flush_in = 1'b1; tick(); flush_in = 1'b0;

    // LSQ exhaustion: a stalled load blocks a following ALU op.
    s0 = strobes;
    push_ops(17, 6'd0, 1'b1, 32'h2000);
    push_ops(1, 6'd1, 1'b0, 32'h3000);
    repeat (5) tick();
    chk("t3_strobes", strobes - s0, 16);
    chk("t3_lsq", lsq_credit_out, 5'd0);
    chk("t3_rs", rs_credit_out, 5'd16);
    chk("t3_stall", disp_en_out, 1'b0);
    lsq_free_in = 1'b1; tick(); lsq_free_in = 1'b0;
    tick();
    chk("t3_load_en", disp_en_out, 1'b1);
    chk("t3_load_ls", disp_is_ls_out, 1'b1);
    chk("t3_load_type", disp_inst_type_out, 6'd11);
    chk("t3_load_pc", disp_pc_out, 32'h2040);
    tick();
    chk("t3_alu_en", disp_en_out, 1'b1);
    chk("t3_alu_ls", disp_is_ls_out, 1'b0);
    chk("t3_alu_pc", disp_pc_out, 32'h3000);
    chk("t3_alu_rs", rs_credit_out, 5'd15);
    rob_free_in = 1'b0;
    flush_in = 1'b1; tick(); flush_in = 1'b0;

    // Flush with 3 queued entries and a simultaneous decoder push.
    push_ops(19, 6'd1, 1'b0, 32'h4000);
    repeat (3) tick();
    chk("t4_rob0", rob_credit_out, 5'd0);
    chk("t4_ready", dec_ready_out, 1'b1);
    set_op(6'd2, 5'd9, 32'h4800);
    dec_valid_in = 1'b1; flush_in = 1'b1; rob_free_in = 1'b1;
    tick();
    dec_valid_in = 1'b0; flush_in = 1'b0; rob_free_in = 1'b0;
    chk("t4_en", disp_en_out, 1'b0);
    chk("t4_rob", rob_credit_out, 5'd16);
    chk("t4_rs", rs_credit_out, 5'd16);
    chk("t4_lsq", lsq_credit_out, 5'd16);
    s0 = strobes;
    repeat (4) tick();
    chk("t4_dropped", strobes - s0, 0);

    // rdy_in low freezes state; free pulses and flush are ignored meanwhile.
    push_ops(1, 6'd1, 1'b0, 32'h5000);
    repeat (2) tick();
    chk("t5_rob15", rob_credit_out, 5'd15);
    push_ops(1, 6'd1, 1'b0, 32'h5100);
    rdy_in = 1'b0; rob_free_in = 1'b1;
    tick();
    chk("t5_frz1_en", disp_en_out, 1'b0);
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    chk("t5_frz2_rob", rob_credit_out, 5'd15);
    tick();
    chk("t5_frz3_en", disp_en_out, 1'b0);
    chk("t5_frz3_rob", rob_credit_out, 5'd15);
    rdy_in = 1'b1; rob_free_in = 1'b0;
    tick();
    chk("t5_go_en", disp_en_out, 1'b1);
    chk("t5_go_pc", disp_pc_out, 32'h5100);
    chk("t5_go_rob", rob_credit_out, 5'd14);

    // Saturation at max, and simultaneous dispatch + free leaves the count unchanged.
    flush_in = 1'b1; tick(); flush_in = 1'b0;
    rob_free_in = 1'b1; tick(); rob_free_in = 1'b0;
    chk("t6_sat", rob_credit_out, 5'd16);
    push_ops(6, 6'd1, 1'b0, 32'h6000);
    repeat (3) tick();
    chk("t6_rob10", rob_credit_out, 5'd10);
    set_op(6'd1, 5'd3, 32'h6100);
    dec_valid_in = 1'b1; tick(); dec_valid_in = 1'b0;
    rob_free_in = 1'b1; tick(); rob_free_in = 1'b0;
    chk("t6_net_en", disp_en_out, 1'b1);
    chk("t6_net_rob", rob_credit_out, 5'd10);
    chk("t6_net_rs", rs_credit_out, 5'd9);

    // Classification bounds: LS_HI is a load/store, LS_HI+1 and LS_LO-1 are not.
    push_ops(1, 6'd18, 1'b0, 32'h6200);
    tick();
    chk("cls_18", disp_is_ls_out, 1'b1);
    push_ops(1, 6'd19, 1'b0, 32'h6300);
    tick();
    chk("cls_19", disp_is_ls_out, 1'b0);
    push_ops(1, 6'd10, 1'b0, 32'h6400);
    tick();
    chk("cls_10", disp_is_ls_out, 1'b0);

    // Asynchronous reset mid-operation discards the queued instruction.
    set_op(6'd1, 5'd1, 32'h7000);
    dec_valid_in = 1'b1; tick();
    set_op(6'd1, 5'd2, 32'h7004);
    tick();
    dec_valid_in = 1'b0;
    chk("t7_pre_en", disp_en_out, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_rst_en", disp_en_out, 1'b0);
    chk("t7_rst_pc", disp_pc_out, 32'd0);
    chk("t7_rst_rob", rob_credit_out, 5'd16);
    chk("t7_rst_rs", rs_credit_out, 5'd16);
    tick(); tick();
    rst_n = 1'b1;
    s0 = strobes;
    repeat (4) tick();
    chk("t7_discard", strobes - s0, 0);
    chk("t7_ready", dec_ready_out, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dispatch_scheduler.md
Name: dispatch_scheduler

Overview:
- Sits between decoder and dispatcher.
- Buffers decoded instructions in a small in-order FIFO and releases at most one per cycle to the dispatcher.
- Releases only when the ROB and the target structure have a free slot: the RS for ALU/branch ops, the LSQ for LB..SW.
- Tracks free slots with credit counters, returned by release pulses. A flush empties the FIFO and restores all credits.

Parameters:
- QDEPTH, 4, instruction FIFO entries (power of 2, >=2)
- ROB_SIZE, 16, ROB entries (initial/max ROB credits)
- RS_SIZE, 16, reservation-station entries (initial/max RS credits)
- LSQ_SIZE, 16, load/store-queue entries (initial/max LSQ credits)
- LS_LO, 11, lowest load/store inst_type code; instantiate with `LB
- LS_HI, 18, highest load/store inst_type code; instantiate with `SW

Ports:
- clk_in  input  1  clock
- rst_in  input  1  reset, asynchronous, active-low
- rdy_in  input  1  global ready; low freezes all state
- flush_in  input  1  misprediction flush
- dec_valid_in  input  1  decoder presents an instruction
- dec_ready_out  output  1  FIFO can accept
- dec_inst_type_in  input  6  instruction type code
- dec_rs1_in  input  5  source register 1
- dec_rs2_in  input  5  source register 2
- dec_rd_in  input  5  destination register
- dec_imm_in  input  32  immediate
- dec_pc_in  input  32  instruction PC
- disp_en_out  output  1  one-cycle dispatch strobe
- disp_inst_type_out  output  6  dispatched type
- disp_rs1_out  output  5  dispatched rs1
- disp_rs2_out  output  5  dispatched rs2
- disp_rd_out  output  5  dispatched rd
- disp_imm_out  output  32  dispatched imm
- disp_pc_out  output  32  dispatched PC
- disp_is_ls_out  output  1  dispatched op goes to LSQ
- rob_free_in  input  1  one ROB entry committed (pulse)
- rs_free_in  input  1  one RS entry issued (pulse)
- lsq_free_in  input  1  one LSQ entry retired (pulse)
- rob_credit_out  output  clog2(ROB_SIZE+1)  current ROB credits
- rs_credit_out  output  clog2(RS_SIZE+1)  current RS credits
- lsq_credit_out  output  clog2(LSQ_SIZE+1)  current LSQ credits

Behaviour:
- **Reset (rst_in low, async):**
  - FIFO empty; head and tail pointers 0.
  - disp_en_out=0; all disp_*_out=0.
  - Credits = ROB_SIZE / RS_SIZE / LSQ_SIZE.
  - dec_ready_out=1 once reset is released.
- **Classification:** is_ls = (LS_LO <= type <= LS_HI), unsigned compare. Computed at enqueue and stored per entry.
- **Accept/enqueue:**
  - dec_ready_out = (count < QDEPTH), combinational, independent of rdy_in and flush_in.
  - Enqueue at the edge where dec_valid_in && dec_ready_out && rdy_in && !flush_in.
- **Dispatch decision:** combinational on the FIFO head.
  - go = !empty && rdy_in && !flush_in && rob_credit>0 && (is_ls ? lsq_credit>0 : rs_credit>0).
  - On go: pop head; register all head fields into disp_*_out; disp_en_out=1 for exactly one cycle; decrement rob_credit and exactly one of rs/lsq_credit.
  - When go is low: disp_en_out=0 and disp_*_out hold their last values.
- **Latency and order:**
  - An instruction enqueued at edge E appears with disp_en_out at edge E+1 at the earliest.
  - There is no same-cycle bypass.
  - Strict in-order dispatch; a head blocked on credits blocks everything behind it.
- **Credit return:**
  - Each free pulse adds 1 to its counter, applied in the same edge as any dispatch decrement (net effect; a simultaneous +1/-1 leaves the value unchanged).
  - An increment that would exceed the maximum saturates at the maximum.
  - The counter never goes below 0, guaranteed by the go condition.
- **Simultaneous enqueue and dequeue:** both happen; count unchanged; pointers wrap mod QDEPTH.
- **Full:** dec_ready_out=0; a dequeue in that cycle does not allow an enqueue in the same cycle.
- **Flush (flush_in=1, rdy_in=1):** takes priority over everything else that cycle.
  - FIFO emptied; no enqueue; no dispatch; disp_en_out=0 next cycle.
  - All credits reset to their maxima; free pulses in that cycle are ignored.
- **rdy_in low:**
  - No enqueue, no dispatch, no credit changes; free pulses and flush_in are ignored.
  - disp_en_out=0 the following cycle.
- **Reset mid-operation:** immediate return to the reset state; in-flight FIFO contents are discarded.

Test Plan:
- Reset then one ADD-type (type 1), rd=5, imm=0x10, pc=0x100 enqueued at edge E -> at edge E+1: disp_en_out=1, disp_rd_out=5, disp_pc_out=0x100, disp_is_ls_out=0; rob_credit 16->15, rs_credit 16->15, lsq_credit stays 16.
- 17 ALU ops with RS_SIZE=16 and no rs_free_in -> exactly 16 strobes; the 17th is held at head; dec_ready_out=0 once 4 more are queued. One rs_free_in pulse -> the 17th dispatches on the next edge.
- Load type (LS_LO) with lsq_credit=0 and rs_credit=16 -> no dispatch and a following ALU op also stalls. lsq_free_in pulse -> load dispatches first with disp_is_ls_out=1, ALU op dispatches the next cycle.
- FIFO holding 3 entries with flush_in=1 and dec_valid_in=1 in the same cycle -> next cycle: FIFO empty, disp_en_out=0, all credits=16, the new instruction is dropped.
- rdy_in held low 3 cycles with a queued op and an rob_free_in pulse -> no strobe and credits unchanged. rdy_in high -> dispatch on the next edge.
- rob_free_in while rob_credit=16 -> stays 16. Dispatch together with rob_free_in at rob_credit=10 -> stays 10.
